dp_sram_pipe: RTL and testbench

- Parametrised dual-port synchronous SRAM; successor to the single-width dp_sram.
- Port A serves instruction fetch; port B serves core load/store.
- Adds per-byte write enables, configurable read latency, a selectable read-during-write policy, out-of-range detection and deterministic write-collision resolution.

---
 rtl/dp_sram_pipe.sv | 179 +++++++++++++++++
 tb/tb_dp_sram_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dp_sram_pipe.sv
// Dual-port synchronous SRAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write policy and out-of-range flagging.
// Port A: instruction fetch. Port B: load/store; B wins write collisions.
module dp_sram_pipe #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = 32,
  parameter int    RD_LAT    = 1,
  parameter int    RDW_MODE  = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_a_req,
  input  logic                i_a_we,
  input  logic [DATA_W/8-1:0] i_a_be,
  input  logic [ADDR_W-1:0]   i_a_addr,
  input  logic [DATA_W-1:0]   i_a_wdata,
  input  logic                i_b_req,
  input  logic                i_b_we,
  input  logic [DATA_W/8-1:0] i_b_be,
  input  logic [ADDR_W-1:0]   i_b_addr,
  input  logic [DATA_W-1:0]   i_b_wdata,
  output logic                o_a_rvalid,
  output logic [DATA_W-1:0]   o_a_rdata,
  output logic                o_a_err,
  output logic                o_b_rvalid,
  output logic [DATA_W-1:0]   o_b_rdata,
  output logic                o_b_err
);

  localparam int     NB        = DATA_W / 8;
  localparam int     OFF_W     = (NB > 1) ? $clog2(NB) : 0;
  localparam int     IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam longint MAX_WORDS = longint'(1) << (ADDR_W - OFF_W);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $fatal(1, "dp_sram_pipe: RD_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $fatal(1, "dp_sram_pipe: DATA_W must be a multiple of 8");
  end
  if (longint'(DEPTH) > MAX_WORDS) begin : g_bad_depth
    $fatal(1, "dp_sram_pipe: DEPTH exceeds the addressable word range");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] a_idx, b_idx;
  logic [IDX_W-1:0]  a_row, b_row;
  logic              a_in, b_in, a_wr, b_wr, a_rd, b_rd;

  assign a_idx = i_a_addr >> OFF_W;
  assign b_idx = i_b_addr >> OFF_W;
  assign a_row = a_idx[IDX_W-1:0];
  assign b_row = b_idx[IDX_W-1:0];
  assign a_in  = (a_idx < ADDR_W'(DEPTH));
  assign b_in  = (b_idx < ADDR_W'(DEPTH));
  assign a_wr  = i_a_req & i_a_we & a_in;
  assign b_wr  = i_b_req & i_b_we & b_in;
  assign a_rd  = i_a_req & ~i_a_we;
  assign b_rd  = i_b_req & ~i_b_we;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int l = 0; l < NB; l++) begin
      if (be[l]) res[l*8 +: 8] = new_w[l*8 +: 8];
    end
    return res;
  endfunction

  // Array write; the B assignment comes last so it wins on shared lanes.
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < NB; l++) begin
      if (a_wr && i_a_be[l]) mem[a_row][l*8 +: 8] <= i_a_wdata[l*8 +: 8];
      if (b_wr && i_b_be[l]) mem[b_row][l*8 +: 8] <= i_b_wdata[l*8 +: 8];
    end
  end

  logic [DATA_W-1:0] a_word, b_word;

  // Array read; in write-first mode the other port's same-cycle write is forwarded.
  always_comb begin
    a_word = mem[a_row];
    b_word = mem[b_row];
    if (RDW_MODE == 1) begin
      if (b_wr && b_row == a_row) a_word = merge(a_word, i_b_wdata, i_b_be);
      if (a_wr && a_row == b_row) b_word = merge(b_word, i_a_wdata, i_a_be);
    end
  end

  logic              a_s1_valid_d, a_s1_valid_q, a_s1_err_d, a_s1_err_q;
  logic              b_s1_valid_d, b_s1_valid_q, b_s1_err_d, b_s1_err_q;
  logic [DATA_W-1:0] a_s1_data_d, a_s1_data_q, b_s1_data_d, b_s1_data_q;

  // First output stage: data only loads on a read, so it holds otherwise.
  always_comb begin
    a_s1_valid_d = a_rd;
    a_s1_err_d   = i_a_req & ~a_in;
    a_s1_data_d  = a_s1_data_q;
    if (a_rd) a_s1_data_d = a_in ? a_word : '0;
    b_s1_valid_d = b_rd;
    b_s1_err_d   = i_b_req & ~b_in;
    b_s1_data_d  = b_s1_data_q;
    if (b_rd) b_s1_data_d = b_in ? b_word : '0;
  end

  // First stage registers; reset drops any read in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_s1_valid_q <= 1'b0;
      a_s1_err_q   <= 1'b0;
      a_s1_data_q  <= '0;
      b_s1_valid_q <= 1'b0;
      b_s1_err_q   <= 1'b0;
      b_s1_data_q  <= '0;
    end else begin
      a_s1_valid_q <= a_s1_valid_d;
      a_s1_err_q   <= a_s1_err_d;
      a_s1_data_q  <= a_s1_data_d;
      b_s1_valid_q <= b_s1_valid_d;
      b_s1_err_q   <= b_s1_err_d;
      b_s1_data_q  <= b_s1_data_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              a_s2_valid_d, a_s2_valid_q, a_s2_err_d, a_s2_err_q;
    logic              b_s2_valid_d, b_s2_valid_q, b_s2_err_d, b_s2_err_q;
    logic [DATA_W-1:0] a_s2_data_d, a_s2_data_q, b_s2_data_d, b_s2_data_q;

    // Extra output stage; stage-1 data already holds, so a plain copy keeps it.
    always_comb begin
      a_s2_valid_d = a_s1_valid_q;
      a_s2_err_d   = a_s1_err_q;
      a_s2_data_d  = a_s1_data_q;
      b_s2_valid_d = b_s1_valid_q;
      b_s2_err_d   = b_s1_err_q;
      b_s2_data_d  = b_s1_data_q;
    end

    // Second stage registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        a_s2_valid_q <= 1'b0;
        a_s2_err_q   <= 1'b0;
        a_s2_data_q  <= '0;
        b_s2_valid_q <= 1'b0;
        b_s2_err_q   <= 1'b0;
        b_s2_data_q  <= '0;
      end else begin
        a_s2_valid_q <= a_s2_valid_d;
        a_s2_err_q   <= a_s2_err_d;
        a_s2_data_q  <= a_s2_data_d;
        b_s2_valid_q <= b_s2_valid_d;
        b_s2_err_q   <= b_s2_err_d;
        b_s2_data_q  <= b_s2_data_d;
      end
    end

    assign o_a_rvalid = a_s2_valid_q;
    assign o_a_err    = a_s2_err_q;
    assign o_a_rdata  = a_s2_data_q;
    assign o_b_rvalid = b_s2_valid_q;
    assign o_b_err    = b_s2_err_q;
    assign o_b_rdata  = b_s2_data_q;
  end else begin : g_lat1
    assign o_a_rvalid = a_s1_valid_q;
    assign o_a_err    = a_s1_err_q;
    assign o_a_rdata  = a_s1_data_q;
    assign o_b_rvalid = b_s1_valid_q;
    assign o_b_err    = b_s1_err_q;
    assign o_b_rdata  = b_s1_data_q;
  end

endmodule

// File: tb/tb_dp_sram_pipe.sv
// Scoreboard bench: two instances (RD_LAT=1/read-first and RD_LAT=2/write-first)
// share one stimulus stream; a word-level memory model predicts every response.
module tb_dp_sram_pipe;

  localparam int DEPTH = 1024;

  logic        clk, rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_be, b_be;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;

  // channel c = 2*instance + port (0 = A, 1 = B)
  logic        rv [4];
  logic        er [4];
  logic [31:0] rd [4];

  dp_sram_pipe #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(1), .RDW_MODE(0), .INIT_FILE("")) u_l1_m0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_be(a_be), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_be(b_be), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_a_rvalid(rv[0]), .o_a_rdata(rd[0]), .o_a_err(er[0]),
    .o_b_rvalid(rv[1]), .o_b_rdata(rd[1]), .o_b_err(er[1]));

  dp_sram_pipe #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(2), .RDW_MODE(1), .INIT_FILE("")) u_l2_m1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_be(a_be), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_be(b_be), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_a_rvalid(rv[2]), .o_a_rdata(rd[2]), .o_a_err(er[2]),
    .o_b_rvalid(rv[3]), .o_b_rdata(rd[3]), .o_b_err(er[3]));

  typedef struct {
    logic        valid;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb [4][$];
  logic [31:0] last_data [4];
  logic [31:0] mem_m [int];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int l = 0; l < 4; l++) if (be[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  // Prediction for one port of one instance, given the other port's write.
  task automatic predict(input int ch, input int lat, input int mode,
                         input logic req, input logic we, input logic [31:0] idx,
                         input logic o_wr, input logic [31:0] o_idx,
                         input logic [31:0] o_wd, input logic [3:0] o_be);
    exp_t e;
    e.cyc = cyc + lat;
    if (req && !we) begin
      e.valid = 1'b1;
      if (idx < DEPTH) begin
        e.err  = 1'b0;
        e.data = mem_m[int'(idx)];
        if (mode == 1 && o_wr && o_idx < DEPTH && o_idx == idx) e.data = lanes(e.data, o_wd, o_be);
      end else begin
        e.err  = 1'b1;
        e.data = '0;
      end
      sb[ch].push_back(e);
    end else if (req && we && idx >= DEPTH) begin
      e.valid = 1'b0;
      e.err   = 1'b1;
      e.data  = '0;
      sb[ch].push_back(e);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [3:0] abe,
                       input logic [31:0] aad, input logic [31:0] awd,
                       input logic br, input logic bw, input logic [3:0] bbe,
                       input logic [31:0] bad, input logic [31:0] bwd);
    logic [31:0] ia, ib;
    ia = aad >> 2;
    ib = bad >> 2;
    a_req = ar; a_we = aw; a_be = abe; a_addr = aad; a_wdata = awd;
    b_req = br; b_we = bw; b_be = bbe; b_addr = bad; b_wdata = bwd;
    for (int d = 0; d < 2; d++) begin
      predict(2*d,   d + 1, d, ar, aw, ia, br && bw, ib, bwd, bbe);
      predict(2*d+1, d + 1, d, br, bw, ib, ar && aw, ia, awd, abe);
    end
    if (ar && aw && ia < DEPTH) mem_m[int'(ia)] = lanes(mem_m[int'(ia)], awd, abe);
    if (br && bw && ib < DEPTH) mem_m[int'(ib)] = lanes(mem_m[int'(ib)], bwd, bbe);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
  endtask

  task automatic flush_sb();
    for (int c = 0; c < 4; c++) begin
      sb[c].delete();
      last_data[c] = '0;
    end
  endtask

  // Monitor: pops an expectation whenever a channel presents rvalid or err.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (!rst_n) begin
        check($sformatf("reset_outputs_ch%0d", c), {30'b0, rv[c], er[c], rd[c]}, 64'b0);
      end else if (rv[c] || er[c]) begin
        if (sb[c].size() == 0) begin
          check($sformatf("unexpected_output_ch%0d", c), {62'b0, rv[c], er[c]}, 64'b0);
        end else begin
          exp_t e;
          e = sb[c].pop_front();
          check($sformatf("latency_ch%0d", c), 64'(cyc), 64'(e.cyc));
          check($sformatf("flags_ch%0d", c), {62'b0, rv[c], er[c]}, {62'b0, e.valid, e.err});
          if (e.valid) begin
            check($sformatf("rdata_ch%0d", c), {32'b0, rd[c]}, {32'b0, e.data});
            last_data[c] = e.data;
          end
        end
      end else begin
        check($sformatf("rdata_hold_ch%0d", c), {32'b0, rd[c]}, {32'b0, last_data[c]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic        ar, aw, br, bw;
    logic [3:0]  abe, bbe;
    logic [31:0] aad, bad, awd, bwd;
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
    flush_sb();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // initialise every word the test touches
    for (int w = 0; w < 64; w++) drive(0, 0, 4'h0, 0, 0, 1, 1, 4'hF, 32'(w * 4), $urandom);

    // basic write then read
    drive(0, 0, 4'h0, 0, 0, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    drive(1, 0, 4'h0, 32'h10, 0, 0, 0, 4'h0, 0, 0);
    // partial write
    drive(0, 0, 4'h0, 0, 0, 1, 1, 4'hF, 32'h20, 32'h11223344);
    drive(0, 0, 4'h0, 0, 0, 1, 1, 4'b0101, 32'h20, 32'hAABBCCDD);
    drive(1, 0, 4'h0, 32'h20, 0, 0, 0, 4'h0, 0, 0);
    // write collision, B wins shared lanes
    drive(1, 1, 4'hF, 32'h40, 32'h01010101, 1, 1, 4'h3, 32'h40, 32'h02020202);
    drive(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 32'h40, 0);
    // read during write from the other port
    drive(0, 0, 4'h0, 0, 0, 1, 1, 4'hF, 32'h80, 32'h5);
    drive(1, 1, 4'hF, 32'h80, 32'h9, 1, 0, 4'h0, 32'h80, 0);
    drive(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 32'h80, 0);
    // streaming reads, unaligned offset ignored on the last
    drive(1, 0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 0, 0);
    drive(1, 0, 4'h0, 32'h4, 0, 0, 0, 4'h0, 0, 0);
    drive(1, 0, 4'h0, 32'h8, 0, 0, 0, 4'h0, 0, 0);
    drive(1, 0, 4'h0, 32'hF, 0, 0, 0, 4'h0, 0, 0);
    // out of range read / write, then confirm word 0 was not aliased
    drive(1, 0, 4'h0, 32'h1000, 0, 0, 0, 4'h0, 0, 0);
    drive(0, 0, 4'h0, 0, 0, 1, 1, 4'hF, 32'h1000, 32'hCAFEF00D);
    drive(1, 1, 4'hF, 32'h1000, 32'h12345678, 1, 0, 4'h0, 32'h0, 0);
    drive(1, 0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 0, 0);
    drive(1, 1, 4'h0, 32'h4, 32'hFFFFFFFF, 1, 0, 4'h0, 32'h4, 0);
    idle(3);

    // randomized traffic concentrated on a few words to provoke hazards
    for (int i = 0; i < 500; i++) begin
      ar  = ($urandom_range(0, 3) != 0);
      aw  = $urandom_range(0, 1) == 1;
      br  = ($urandom_range(0, 3) != 0);
      bw  = $urandom_range(0, 1) == 1;
      abe = 4'($urandom);
      bbe = 4'($urandom);
      awd = $urandom;
      bwd = $urandom;
      aad = ($urandom_range(0, 19) < 2) ? 32'(DEPTH + $urandom_range(0, 7)) : 32'($urandom_range(0, 7));
      bad = ($urandom_range(0, 19) < 2) ? 32'(DEPTH + $urandom_range(0, 7)) : 32'($urandom_range(0, 7));
      aad = (aad << 2) | 32'($urandom_range(0, 3));
      bad = (bad << 2) | 32'($urandom_range(0, 3));
      drive(ar, aw, abe, aad, awd, br, bw, bbe, bad, bwd);
    end
    idle(3);

    // reset with reads in flight: nothing may emerge afterwards
    drive(1, 0, 4'h0, 32'h0, 0, 1, 0, 4'h0, 32'h4, 0);
    drive(1, 0, 4'h0, 32'h8, 0, 1, 0, 4'h0, 32'hC, 0);
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    #2;
    rst_n = 1'b0;
    flush_sb();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    drive(1, 0, 4'h0, 32'h8, 0, 1, 0, 4'h0, 32'h1004, 0);
    idle(4);

    for (int c = 0; c < 4; c++) check($sformatf("scoreboard_empty_ch%0d", c), 64'(sb[c].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
